btn_pm_ctl: RTL and testbench

- Upstream conditioning stage for the board top-level power-management logic.
- Takes the raw, asynchronous push-button lines and synchronizes them, then debounces them.
- Emits clean levels plus one-cycle press/release pulses.
- Classifies presses on one designated button:
  - a short press emits a reset request (rst_req);
  - a long hold emits a shutdown request (shdn_req).
- The top-level power-management always block consumes rst_req/shdn_req in place of the raw center-button sample.

---
 rtl/btn_pm_ctl.sv | 136 +++++++++++++
 tb/tb_btn_pm_ctl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pm_ctl.sv
// Push-button conditioning: per-bit synchronizer and debouncer with press/release pulses,
// plus a short/long press classifier on one button that raises reset/shutdown requests.
module btn_pm_ctl #(
  parameter int N_BTN       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 250000,
  parameter int LONG_CYCLES = 50000000,
  parameter int RST_IDX     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             rst_req,
  output logic             shdn_req
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [CW-1:0]    cnt_q [N_BTN];
  state_t           state_q;
  logic [HW-1:0]    hcnt_q;
  logic             rst_req_q;
  logic             shdn_req_q;

  // Plain flop chain; stage 0 is the only flop that sees the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level change is accepted only after DB_CYCLES consecutive differing samples;
  // the edge pulses are registered alongside stable_q so they line up with btn_level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          stable_q[i]  <= s[i];
          cnt_q[i]     <= '0;
          press_q[i]   <= s[i];
          release_q[i] <= ~s[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Classifier: release is checked before the hold limit, so a release landing on
  // the last hold cycle still counts as a short press. hcnt freezes in ST_LONG.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hcnt_q     <= '0;
      rst_req_q  <= 1'b0;
      shdn_req_q <= 1'b0;
    end else begin
      rst_req_q  <= 1'b0;
      shdn_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press_q[RST_IDX]) begin
            state_q <= ST_HELD;
            hcnt_q  <= HW'(1);
          end
        end
        ST_HELD: begin
          if (release_q[RST_IDX]) begin
            rst_req_q <= 1'b1;
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
          end else if (hcnt_q == HOLD_LAST) begin
            shdn_req_q <= 1'b1;
            state_q    <= ST_LONG;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        ST_LONG: begin
          if (release_q[RST_IDX]) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign rst_req     = rst_req_q;
  assign shdn_req    = shdn_req_q;

endmodule

// File: tb/tb_btn_pm_ctl.sv
// Directed bench for btn_pm_ctl with short debounce/hold constants; cycle numbers are
// counted from the first clock edge that samples a new raw value.
module tb_btn_pm_ctl;

  localparam int N_BTN = 5;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             rst_req;
  logic             shdn_req;

  int tests_run;
  int tests_failed;
  int cyc;

  btn_pm_ctl #(
    .N_BTN      (N_BTN),
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .LONG_CYCLES(20),
    .RST_IDX    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .rst_req    (rst_req),
    .shdn_req   (shdn_req)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = '0;
    repeat (3) step();
    tests_run++;
    if (btn_level !== 5'b0) begin
      tests_failed++; $display("FAIL reset_level: got %b want 00000", btn_level);
    end
    tests_run++;
    if ((btn_press | btn_release) !== 5'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got %b/%b want 0", btn_press, btn_release);
    end
    tests_run++;
    if ({rst_req, shdn_req} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_reqs: got %b want 00", {rst_req, shdn_req});
    end
    rst_n = 1'b1;
    repeat (4) step();
    tests_run++;
    if (btn_level !== 5'b0) begin
      tests_failed++; $display("FAIL post_reset_level: got %b want 00000", btn_level);
    end
  endtask

  task automatic test_glitch();
    int lvl_seen;
    int pulse_seen;
    lvl_seen   = 0;
    pulse_seen = 0;
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (btn_level[0]) lvl_seen++;
      if (btn_press[0] || btn_release[0]) pulse_seen++;
    end
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (btn_level[0]) lvl_seen++;
      if (btn_press[0] || btn_release[0]) pulse_seen++;
    end
    tests_run++;
    if (lvl_seen !== 0 || pulse_seen !== 0) begin
      tests_failed++;
      $display("FAIL glitch_single: got level=%0d pulses=%0d want 0/0", lvl_seen, pulse_seen);
    end
    for (int c = 0; c < 40; c++) begin
      btn_raw[0] = ((c % 4) != 3);
      step();
      if (btn_level[0]) lvl_seen++;
      if (btn_press[0] || btn_release[0]) pulse_seen++;
    end
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (btn_level[0]) lvl_seen++;
      if (btn_press[0] || btn_release[0]) pulse_seen++;
    end
    tests_run++;
    if (lvl_seen !== 0 || pulse_seen !== 0) begin
      tests_failed++;
      $display("FAIL glitch_train: got level=%0d pulses=%0d want 0/0", lvl_seen, pulse_seen);
    end
  endtask

  task automatic test_clean_press();
    int rise_c, press_c, press_n, fall_c, rel_c, rel_n, req_n;
    rise_c = -1; press_c = -1; press_n = 0;
    fall_c = -1; rel_c = -1; rel_n = 0; req_n = 0;
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (btn_level[1] && rise_c < 0) rise_c = c;
      if (btn_press[1]) begin press_n++; press_c = c; end
      if (rst_req || shdn_req) req_n++;
    end
    tests_run++;
    if (rise_c !== 6) begin
      tests_failed++; $display("FAIL clean_rise_cycle: got %0d want 6", rise_c);
    end
    tests_run++;
    if (press_n !== 1 || press_c !== 6) begin
      tests_failed++; $display("FAIL clean_press_pulse: got n=%0d at %0d want 1 at 6", press_n, press_c);
    end
    btn_raw[1] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (!btn_level[1] && fall_c < 0) fall_c = c;
      if (btn_release[1]) begin rel_n++; rel_c = c; end
      if (rst_req || shdn_req) req_n++;
    end
    tests_run++;
    if (fall_c !== 6) begin
      tests_failed++; $display("FAIL clean_fall_cycle: got %0d want 6", fall_c);
    end
    tests_run++;
    if (rel_n !== 1 || rel_c !== 6) begin
      tests_failed++; $display("FAIL clean_release_pulse: got n=%0d at %0d want 1 at 6", rel_n, rel_c);
    end
    tests_run++;
    if (req_n !== 0) begin
      tests_failed++; $display("FAIL clean_no_req: got %0d want 0", req_n);
    end
  endtask

  task automatic test_short_press();
    int press_c, rel_c, rq_c, rq_n, sd_n, both_n;
    press_c = -1; rel_c = -1; rq_c = -1; rq_n = 0; sd_n = 0; both_n = 0;
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (btn_press[4]) press_c = c;
      if (rst_req) rq_n++;
      if (shdn_req) sd_n++;
    end
    btn_raw[4] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (btn_release[4]) rel_c = c;
      if (rst_req) begin rq_n++; rq_c = c; end
      if (shdn_req) sd_n++;
      if (rst_req && shdn_req) both_n++;
    end
    tests_run++;
    if (press_c !== 6) begin
      tests_failed++; $display("FAIL short_press_cycle: got %0d want 6", press_c);
    end
    tests_run++;
    if (rq_n !== 1 || rq_c !== 7 || rel_c !== 6) begin
      tests_failed++;
      $display("FAIL short_rst_req: got n=%0d at %0d rel at %0d want 1 at 7 rel at 6", rq_n, rq_c, rel_c);
    end
    tests_run++;
    if (sd_n !== 0 || both_n !== 0) begin
      tests_failed++; $display("FAIL short_no_shdn: got shdn=%0d both=%0d want 0/0", sd_n, both_n);
    end
  endtask

  task automatic test_long_press();
    int press_c, sd_c, sd_n, rq_n, rel_n, rel_c;
    press_c = -1; sd_c = -1; sd_n = 0; rq_n = 0; rel_n = 0; rel_c = -1;
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (btn_press[4]) press_c = c;
      if (shdn_req) begin sd_n++; sd_c = c; end
      if (rst_req) rq_n++;
    end
    tests_run++;
    if (press_c !== 6) begin
      tests_failed++; $display("FAIL long_press_cycle: got %0d want 6", press_c);
    end
    tests_run++;
    if (sd_n !== 1 || sd_c !== 26) begin
      tests_failed++; $display("FAIL long_shdn_req: got n=%0d at %0d want 1 at 26", sd_n, sd_c);
    end
    btn_raw[4] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (btn_release[4]) begin rel_n++; rel_c = c; end
      if (shdn_req) sd_n++;
      if (rst_req) rq_n++;
    end
    tests_run++;
    if (rel_n !== 1 || rel_c !== 6) begin
      tests_failed++; $display("FAIL long_release: got n=%0d at %0d want 1 at 6", rel_n, rel_c);
    end
    tests_run++;
    if (rq_n !== 0 || sd_n !== 1) begin
      tests_failed++; $display("FAIL long_no_extra_req: got rst=%0d shdn=%0d want 0/1", rq_n, sd_n);
    end
  endtask

  // Release becomes visible on the cycle the hold count sits at its last value.
  task automatic test_release_wins();
    int pc, found, rel_c, rq_c, rq_n, sd_n;
    pc = 0; found = 0; rel_c = -1; rq_c = -1; rq_n = 0; sd_n = 0;
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      if (btn_press[4]) found = 1;
    end
    tests_run++;
    if (found !== 1) begin
      tests_failed++; $display("FAIL edge_press_found: got %0d want 1", found);
    end
    for (int c = 1; c <= 13; c++) begin
      step();
      pc++;
      if (rst_req) rq_n++;
      if (shdn_req) sd_n++;
    end
    btn_raw[4] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      step();
      pc++;
      if (btn_release[4]) rel_c = pc;
      if (rst_req) begin rq_n++; rq_c = pc; end
      if (shdn_req) sd_n++;
    end
    tests_run++;
    if (rel_c !== 19 || rq_n !== 1 || rq_c !== 20) begin
      tests_failed++;
      $display("FAIL edge_release_wins: got rel=%0d rst n=%0d at %0d want rel=19 rst 1 at 20", rel_c, rq_n, rq_c);
    end
    tests_run++;
    if (sd_n !== 0) begin
      tests_failed++; $display("FAIL edge_no_shdn: got %0d want 0", sd_n);
    end
  endtask

  task automatic test_reset_mid_hold();
    int found, press_c, sd_c, sd_n, rq_n;
    found = 0; press_c = -1; sd_c = -1; sd_n = 0; rq_n = 0;
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      if (btn_press[4]) found = 1;
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      if (shdn_req) sd_n++;
      if (rst_req) rq_n++;
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({btn_level, btn_press, btn_release, rst_req, shdn_req} !== 17'b0) begin
      tests_failed++;
      $display("FAIL midhold_reset_outputs: got lvl=%b p=%b r=%b rq=%b sd=%b want all 0",
               btn_level, btn_press, btn_release, rst_req, shdn_req);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (btn_press[4]) press_c = c;
      if (shdn_req) begin sd_n++; sd_c = c; end
      if (rst_req) rq_n++;
    end
    tests_run++;
    if (found !== 1 || press_c !== 6) begin
      tests_failed++; $display("FAIL midhold_repress: got found=%0d at %0d want 1 at 6", found, press_c);
    end
    tests_run++;
    if (sd_n !== 1 || sd_c !== 26) begin
      tests_failed++; $display("FAIL midhold_shdn: got n=%0d at %0d want 1 at 26", sd_n, sd_c);
    end
    btn_raw[4] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (rst_req) rq_n++;
    end
    tests_run++;
    if (rq_n !== 0) begin
      tests_failed++; $display("FAIL midhold_no_rst: got %0d want 0", rq_n);
    end
  endtask

  task automatic test_independent();
    int p0_c, p3_c, other_n, req_n;
    p0_c = -1; p3_c = -1; other_n = 0; req_n = 0;
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (btn_press[0]) p0_c = c;
      if (btn_press[3]) p3_c = c;
      if (btn_press[1] || btn_press[2] || btn_press[4]) other_n++;
      if (rst_req || shdn_req) req_n++;
    end
    tests_run++;
    if (p0_c !== 6 || p3_c !== 6) begin
      tests_failed++; $display("FAIL indep_press_cycles: got %0d/%0d want 6/6", p0_c, p3_c);
    end
    tests_run++;
    if (btn_level !== 5'b01001 || other_n !== 0) begin
      tests_failed++; $display("FAIL indep_levels: got %b others=%0d want 01001/0", btn_level, other_n);
    end
    btn_raw = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (rst_req || shdn_req) req_n++;
    end
    tests_run++;
    if (req_n !== 0 || btn_level !== 5'b0) begin
      tests_failed++; $display("FAIL indep_no_req: got req=%0d lvl=%b want 0/00000", req_n, btn_level);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    btn_raw      = '0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_short_press();
    test_long_press();
    test_release_wins();
    test_reset_mid_hold();
    test_independent();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
